// File: rtl/hazard_pkg.sv
// Shared definitions for the RAW hazard controller.
// FSM state encodings and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// ID-side bundle between the decode stage and the hazard controller.
// master drives decoded/producer info, slave returns stall controls.
interface hazard_ctrl_unit_if #(
    parameter int NB_REG_ADDR = 5,
    parameter int N_SRC       = 2,
    parameter int N_PROD      = 3,
    parameter int MAX_STALL   = 4,
    parameter int NB_PERF     = 32
);
    localparam int NB_CNT = $clog2(MAX_STALL + 1);

    logic                          i_valid;
    logic [N_SRC*NB_REG_ADDR-1:0]  i_src_addr;
    logic [N_SRC-1:0]              i_src_used;
    logic                          i_early_use;
    logic [N_PROD*NB_REG_ADDR-1:0] i_prod_addr;
    logic [N_PROD-1:0]             i_prod_we;
    logic [N_PROD-1:0]             i_prod_rdy_ex;
    logic [N_PROD-1:0]             i_prod_rdy_id;
    logic                          i_perf_clr;
    logic                          o_stall;
    logic                          o_bubble;
    logic [NB_CNT-1:0]             o_stall_cnt;
    logic                          o_timeout;
    logic [NB_PERF-1:0]            o_perf_cycles;
    logic [NB_PERF-1:0]            o_perf_events;

    modport master (
        output i_valid, i_src_addr, i_src_used, i_early_use,
        output i_prod_addr, i_prod_we, i_prod_rdy_ex, i_prod_rdy_id,
        output i_perf_clr,
        input  o_stall, o_bubble, o_stall_cnt, o_timeout,
        input  o_perf_cycles, o_perf_events
    );

    modport slave (
        input  i_valid, i_src_addr, i_src_used, i_early_use,
        input  i_prod_addr, i_prod_we, i_prod_rdy_ex, i_prod_rdy_id,
        input  i_perf_clr,
        output o_stall, o_bubble, o_stall_cnt, o_timeout,
        output o_perf_cycles, o_perf_events
    );

endinterface

// File: rtl/hazard_match.sv
// Per-producer RAW check: any used source reading this stage's
// non-r0 destination while the result is not yet forwardable.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int NB_REG_ADDR = 5,
    parameter int N_SRC       = 2
) (
    input  logic [N_SRC*NB_REG_ADDR-1:0] i_src_addr,
    input  logic [N_SRC-1:0]             i_src_used,
    input  logic [NB_REG_ADDR-1:0]       i_prod_addr,
    input  logic                         i_prod_we,
    input  logic                         i_prod_rdy,
    output logic                         o_haz
);

    logic [N_SRC-1:0] w_hit;
    logic             w_dest_ok;

    assign w_dest_ok = i_prod_we &
                       (i_prod_addr != NB_REG_ADDR'(REG_ZERO));

    genvar j;
    generate
        for (j = 0; j < N_SRC; j++) begin : g_src
            assign w_hit[j] = i_src_used[j] & w_dest_ok &
                (i_src_addr[j*NB_REG_ADDR +: NB_REG_ADDR] == i_prod_addr);
        end
    endgenerate

    assign o_haz = (|w_hit) & ~i_prod_rdy;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// RAW hazard detector / stall controller beside ID with stall watchdog.
// Optional saturating perf counters enabled by defining HAZ_PERF_EN.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int NB_REG_ADDR = 5,
    parameter int N_SRC       = 2,
    parameter int N_PROD      = 3,
    parameter int MAX_STALL   = 4,
    parameter int NB_PERF     = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    hazard_ctrl_unit_if.slave bus
);

    localparam int NB_CNT = $clog2(MAX_STALL + 1);

    state_e            r_state;
    logic [NB_CNT-1:0] r_cnt;
    logic              r_timeout;

    logic [N_PROD-1:0] w_rdy;
    logic [N_PROD-1:0] w_haz_k;
    logic              w_haz;
    logic              w_stall;
    logic              w_event;

    genvar k;
    generate
        for (k = 0; k < N_PROD; k++) begin : g_prod
            assign w_rdy[k] = bus.i_early_use ? bus.i_prod_rdy_id[k]
                                              : bus.i_prod_rdy_ex[k];
            hazard_match #(
                .NB_REG_ADDR (NB_REG_ADDR),
                .N_SRC       (N_SRC)
            ) u_match (
                .i_src_addr  (bus.i_src_addr),
                .i_src_used  (bus.i_src_used),
                .i_prod_addr (bus.i_prod_addr[k*NB_REG_ADDR +: NB_REG_ADDR]),
                .i_prod_we   (bus.i_prod_we[k]),
                .i_prod_rdy  (w_rdy[k]),
                .o_haz       (w_haz_k[k])
            );
        end
    endgenerate

    // The RELEASE cycle lets the held instruction through to break livelock.
    assign w_haz   = |w_haz_k;
    assign w_stall = w_haz & bus.i_valid & i_reset &
                     (r_state != ST_RELEASE);
    assign w_event = w_haz & bus.i_valid & (r_state == ST_IDLE);

    // Stall FSM with consecutive-cycle watchdog and sticky timeout flag.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (bus.i_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_haz) begin
                        r_state <= ST_STALL;
                        r_cnt   <= NB_CNT'(1);
                    end
                end
                ST_STALL: begin
                    if (!w_haz) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt < NB_CNT'(MAX_STALL)) begin
                        r_cnt <= r_cnt + NB_CNT'(1);
                    end else begin
                        r_state   <= ST_RELEASE;
                        r_timeout <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.o_stall     = w_stall;
    assign bus.o_bubble    = w_stall;
    assign bus.o_stall_cnt = r_cnt;
    assign bus.o_timeout   = r_timeout;

`ifdef HAZ_PERF_EN
    logic [NB_PERF-1:0] r_perf_cycles;
    logic [NB_PERF-1:0] r_perf_events;

    // Saturating stall-cycle and stall-episode counters; clear has priority.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_perf_cycles <= '0;
            r_perf_events <= '0;
        end else if (bus.i_perf_clr) begin
            r_perf_cycles <= '0;
            r_perf_events <= '0;
        end else begin
            if (w_stall && (r_perf_cycles != '1)) begin
                r_perf_cycles <= r_perf_cycles + NB_PERF'(1);
            end
            if (w_event && (r_perf_events != '1)) begin
                r_perf_events <= r_perf_events + NB_PERF'(1);
            end
        end
    end

    assign bus.o_perf_cycles = r_perf_cycles;
    assign bus.o_perf_events = r_perf_events;
`else
    logic w_unused_perf_clr;
    assign w_unused_perf_clr = bus.i_perf_clr;
    assign bus.o_perf_cycles = '0;
    assign bus.o_perf_events = '0;
`endif

endmodule
